// File: rtl/uart_baud_gen_if.sv
// Control and tick signals of the fractional baud-tick generator.
// The master side drives the divisor and strobes. The slave side is the generator.
interface uart_baud_gen_if #(
   parameter int unsigned DIV_W  = 20,
   parameter int unsigned FRAC_W = 4
);
   logic              Enable;
   logic              Load;
   logic [DIV_W-1:0]  DivInt;
   logic [FRAC_W-1:0] DivFrac;
   logic              Resync;
   logic              RxTick;
   logic              TxTick;
   logic              CfgErr;

   modport master (
      output Enable, Load, DivInt, DivFrac, Resync,
      input  RxTick, TxTick, CfgErr
   );

   modport slave (
      input  Enable, Load, DivInt, DivFrac, Resync,
      output RxTick, TxTick, CfgErr
   );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud-tick generator.
// One divider produces the receiver oversample tick (RxTick). Every OVERSAMPLE-th
// RxTick is also flagged as the transmitter bit tick (TxTick), so both ticks share one phase.
module uart_baud_gen #(
   parameter int unsigned DIV_W      = 20,
   parameter int unsigned FRAC_W     = 4,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned RST_DIV    = 54,
   parameter int unsigned RST_FRAC   = 4
) (
   input logic            CLK,
   input logic            RST,
   uart_baud_gen_if.slave bus
);
   localparam int unsigned SUB_W = $clog2(OVERSAMPLE);

   logic [DIV_W-1:0]  act_int;
   logic [FRAC_W-1:0] act_frac;
   logic [DIV_W-1:0]  counter;
   logic [SUB_W-1:0]  sub_count;
   logic [FRAC_W-1:0] frac_acc;
   logic              extend;
   logic              rx_tick;
   logic              tx_tick;
   logic              cfg_err;

   logic [DIV_W:0]    period;
   logic              wrap;
   logic [FRAC_W:0]   frac_sum;
   logic              load_ok;

   // Current period (one bit wider so ActInt = max plus Extend still fits), the wrap detect, and the fractional carry.
   always_comb begin
      period   = {1'b0, act_int} + {{DIV_W{1'b0}}, extend};
      wrap     = ({1'b0, counter} == (period - (DIV_W+1)'(1)));
      frac_sum = {1'b0, frac_acc} + {1'b0, act_frac};
      load_ok  = bus.Load && (bus.DivInt >= DIV_W'(2));
   end

   // Divisor registers, counters and tick outputs. A legal Load has priority over Resync.
   // A Load or Resync restarts the phase and discards any wrap in the same cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         act_int   <= DIV_W'(RST_DIV);
         act_frac  <= FRAC_W'(RST_FRAC);
         counter   <= '0;
         sub_count <= '0;
         frac_acc  <= '0;
         extend    <= 1'b0;
         rx_tick   <= 1'b0;
         tx_tick   <= 1'b0;
         cfg_err   <= 1'b0;
      end else if (load_ok) begin
         act_int   <= bus.DivInt;
         act_frac  <= bus.DivFrac;
         counter   <= '0;
         sub_count <= '0;
         frac_acc  <= '0;
         extend    <= 1'b0;
         rx_tick   <= 1'b0;
         tx_tick   <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         if (bus.Load) begin
            cfg_err <= 1'b1;
         end
         if (bus.Resync) begin
            counter   <= '0;
            sub_count <= '0;
            frac_acc  <= '0;
            extend    <= 1'b0;
            rx_tick   <= 1'b0;
            tx_tick   <= 1'b0;
         end else if (bus.Enable) begin
            if (wrap) begin
               counter   <= '0;
               sub_count <= sub_count + SUB_W'(1);
               frac_acc  <= frac_sum[FRAC_W-1:0];
               extend    <= frac_sum[FRAC_W];
               rx_tick   <= 1'b1;
               tx_tick   <= (sub_count == '1);
            end else begin
               counter <= counter + DIV_W'(1);
               rx_tick <= 1'b0;
               tx_tick <= 1'b0;
            end
         end else begin
            rx_tick <= 1'b0;
            tx_tick <= 1'b0;
         end
      end
   end

   assign bus.RxTick = rx_tick;
   assign bus.TxTick = tx_tick;
   assign bus.CfgErr = cfg_err;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Testbench for uart_baud_gen.
// Expected tick edges come from the closed-form schedule.
// Tick n of a phase lands after n*Int + floor((n-1)*Frac/2^FRAC_W) enabled clocks.
// Every OVERSAMPLE-th tick also carries TxTick.
module tb_uart_baud_gen;
   localparam int DIV_W    = 20;
   localparam int FRAC_W   = 4;
   localparam int OS       = 16;
   localparam int RST_DIV  = 54;
   localparam int RST_FRAC = 4;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

   uart_baud_gen #(
      .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
      .RST_DIV(RST_DIV), .RST_FRAC(RST_FRAC)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      longint edge_no;
      bit     tx;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   longint      cyc = 0;

   // Reference state: active divisor, enabled clocks in this phase, index of next tick
   longint m_int, m_frac, m_en, m_n;
   bit     exp_cfg;

   // Count every rising clock edge.
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic longint t_of(longint n);
      return n * m_int + (((n - 1) * m_frac) >> FRAC_W);
   endfunction

   task automatic check(string name, longint act, longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_reset();
      m_int = RST_DIV; m_frac = RST_FRAC; m_en = 0; m_n = 1; exp_cfg = 1'b0;
   endtask

   // Apply one cycle of stimulus, then advance the reference model over that edge.
   task automatic step(bit en, bit ld, longint di, longint df, bit rs);
      bus.Enable  = en;
      bus.Load    = ld;
      bus.DivInt  = DIV_W'(di);
      bus.DivFrac = FRAC_W'(df);
      bus.Resync  = rs;
      @(posedge CLK);
      #1;
      if (ld && di >= 2) begin
         m_int = di; m_frac = df; m_en = 0; m_n = 1; exp_cfg = 1'b0;
      end else begin
         if (ld) exp_cfg = 1'b1;
         if (rs) begin
            m_en = 0; m_n = 1;
         end else if (en) begin
            m_en++;
            if (m_en == t_of(m_n)) begin
               sb.push_back(exp_t'{cyc, (m_n % OS) == 0});
               m_n++;
            end
         end
      end
      check("cfg_err", longint'(bus.CfgErr), longint'(exp_cfg));
      bus.Load   = 1'b0;
      bus.Resync = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0);
   endtask

   // Monitor: match each observed tick against the scoreboard, and flag expected ticks that never came.
   always @(negedge CLK) begin
      if (!RST) begin
         while (sb.size() > 0 && sb[0].edge_no < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_missing: no tick by edge %0d, required at edge %0d", cyc, sb[0].edge_no);
            void'(sb.pop_front());
         end
         if (bus.RxTick) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rx_unexpected: tick at edge %0d, required none", cyc);
            end else begin
               e = sb.pop_front();
               check("rx_edge", cyc, e.edge_no);
               check("tx_tick", longint'(bus.TxTick), longint'(e.tx));
            end
         end else if (bus.TxTick) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_alone: TxTick=1 without RxTick at edge %0d, required 0", cyc);
         end
      end
   end

   initial begin
      int  guard;
      bit  got_tx;
      bus.Enable = 1'b0; bus.Load = 1'b0; bus.Resync = 1'b0;
      bus.DivInt = '0; bus.DivFrac = '0;

      // Outputs during reset
      repeat (3) @(posedge CLK);
      #1;
      check("reset_rx", longint'(bus.RxTick), 0);
      check("reset_tx", longint'(bus.TxTick), 0);
      check("reset_cfg", longint'(bus.CfgErr), 0);
      RST = 1'b0;
      model_reset();

      // Default divisor 54.25. An illegal Load keeps the default and sets CfgErr.
      // Run until the 16th tick, then reset while RxTick and TxTick are both high.
      step(1'b1, 1'b1, 1, 0, 1'b0);
      got_tx = 1'b0;
      guard  = 0;
      while (!got_tx && guard < 2000) begin
         idle(1);
         guard++;
         if (sb.size() > 0 && sb[$].tx && sb[$].edge_no == cyc) got_tx = 1'b1;
      end
      check("default_tx_reached", longint'(got_tx), 1);
      #2;
      RST = 1'b1;
      #1;
      check("midrst_rx", longint'(bus.RxTick), 0);
      check("midrst_tx", longint'(bus.TxTick), 0);
      check("midrst_cfg", longint'(bus.CfgErr), 0);
      sb.delete();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      model_reset();

      // Integer divisor 4: RxTick every 4 clocks, TxTick every 64 clocks.
      step(1'b1, 1'b1, 4, 0, 1'b0);
      idle(140);
      // Divisor 4.5: intervals alternate between 4 and 5.
      step(1'b1, 1'b1, 4, 8, 1'b0);
      idle(160);
      // Illegal Load keeps 4.5. A legal Load of 3 then clears CfgErr.
      step(1'b1, 1'b1, 1, 0, 1'b0);
      idle(30);
      step(1'b1, 1'b1, 3, 0, 1'b0);
      idle(60);
      // Divisor 10, Resync while Counter = 6.
      step(1'b1, 1'b1, 10, 0, 1'b0);
      idle(6);
      step(1'b1, 1'b0, 0, 0, 1'b1);
      idle(170);
      // Divisor 8, Enable low for 5 clocks while Counter = 3.
      step(1'b1, 1'b1, 8, 0, 1'b0);
      idle(3);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
      idle(40);
      // Minimum divisor, then Load+Resync, illegal Load+Resync, and strobes with Enable low.
      step(1'b1, 1'b1, 2, 0, 1'b0);
      idle(40);
      step(1'b1, 1'b1, 5, 3, 1'b1);
      idle(30);
      step(1'b1, 1'b1, 0, 0, 1'b1);
      idle(30);
      step(1'b0, 1'b1, 6, 0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
      idle(20);
      step(1'b0, 1'b0, 0, 0, 1'b1);
      idle(40);
      step(1'b1, 1'b1, 2, 15, 1'b0);
      idle(100);

      // Random Enable gaps, Loads (some illegal) and Resyncs.
      for (int i = 0; i < 4000; i++) begin
         step(1'($urandom_range(0, 99) >= 10),
              1'($urandom_range(0, 99) < 2),
              longint'($urandom_range(0, 12)),
              longint'($urandom_range(0, 15)),
              1'($urandom_range(0, 99) < 2));
      end
      idle(20);
      @(negedge CLK);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
